// File: rtl/blur3x3_pkg.sv
// Shared types and constants for the 3x3 box-blur engine: FSM state encoding,
// sum width and the reciprocal constant used to divide a 9-pixel sum by 9.
package blur3x3_pkg;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    RD0  = 4'd1,
    RD1  = 4'd2,
    RD2  = 4'd3,
    CAP  = 4'd4,
    SUM  = 4'd5,
    OUT  = 4'd6,
    NEXT = 4'd7,
    FIN  = 4'd8
  } state_t;

  // Nine pixels of dw bits never exceed 9*(2^dw-1) < 2^(dw+4).
  function automatic int sum_width(input int dw);
    return dw + 32'sd4;
  endfunction

  // With shift = sw+3 and recip = ceil(2^shift/9), the reciprocal error is at
  // most 8, so s*err < 2^shift for every s < 2^sw and floor(s*recip >> shift)
  // equals floor(s/9) exactly.
  function automatic int div9_shift(input int sw);
    return sw + 32'sd3;
  endfunction

  function automatic int div9_recip(input int sh);
    return ((32'sd1 << sh) + 32'sd8) / 32'sd9;
  endfunction

  // Precomputed values for the 8-bit pixel build (12-bit sum).
  localparam int DIV9_SHIFT = 15;
  localparam int DIV9_RECIP = 3641;

endpackage

// File: rtl/blur3x3_div9.sv
// Combinational 9-pixel adder tree followed by an exact divide-by-9 done as a
// constant reciprocal multiply. Macro BLUR_ROUND_EN selects round-to-nearest
// (floor((sum+4)/9)); otherwise the result is floor(sum/9).
module blur3x3_div9
  import blur3x3_pkg::*;
#(
  parameter int data_w = 8
) (
  input  logic [3*data_w-1:0] row0,
  input  logic [3*data_w-1:0] row1,
  input  logic [3*data_w-1:0] row2,
  output logic [data_w-1:0]   q
);

  localparam int SW = sum_width(data_w);
  localparam int SH = (data_w == 8) ? DIV9_SHIFT : div9_shift(SW);
  localparam int RC = (data_w == 8) ? DIV9_RECIP : div9_recip(SH);
  localparam logic [SW+SH-1:0] RECIP_V = (SW+SH)'(RC);
  localparam logic [SW-1:0]    QMAX    = {{4{1'b0}}, {data_w{1'b1}}};

  logic [SW-1:0]    r0_sum, r1_sum, r2_sum, total, dividend, quo;
  logic [SW+SH-1:0] prod;

  function automatic logic [SW-1:0] row_sum(input logic [3*data_w-1:0] t);
    return SW'(t[data_w-1:0]) + SW'(t[2*data_w-1:data_w]) + SW'(t[3*data_w-1:2*data_w]);
  endfunction

  // Sum the three triplets, divide by 9 and clamp to the pixel range.
  always_comb begin
    r0_sum = row_sum(row0);
    r1_sum = row_sum(row1);
    r2_sum = row_sum(row2);
    total  = r0_sum + r1_sum + r2_sum;
`ifdef BLUR_ROUND_EN
    dividend = total + SW'(4);
`else
    dividend = total;
`endif
    prod = (SW+SH)'(dividend) * RECIP_V;
    quo  = SW'(prod >> SH);
    if (quo > QMAX) begin
      q = {data_w{1'b1}};
    end else begin
      q = quo[data_w-1:0];
    end
  end

endmodule

// File: rtl/blur3x3_engine.sv
// 3x3 box-blur sequencer: walks a W x H frame stored in a 3-pixel-wide memory,
// reads three row triplets per output pixel, averages them and presents the
// (W-2) x (H-2) result on a valid/ready port. Optional macro BLUR_ROUND_EN
// (consumed by blur3x3_div9) switches to round-to-nearest division.
module blur3x3_engine
  import blur3x3_pkg::*;
#(
  parameter int addr_w   = 8,
  parameter int data_w   = 8,
  parameter int IMG_W    = 16,
  parameter int IMG_H    = 16,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  output logic [addr_w-1:0]   ADDR,
  output logic                RD,
  input  logic [3*data_w-1:0] MDATA,
  output logic [addr_w-1:0]   OADDR,
  output logic [data_w-1:0]   ODATA,
  output logic                OVALID,
  input  logic                OREADY,
  output logic                BUSY,
  output logic                DONE
);

  generate
    if (IMG_W < 3 || IMG_H < 3) begin : g_bad_size
      $error("blur3x3_engine: IMG_W and IMG_H must both be at least 3");
    end
  endgenerate

  localparam logic [addr_w-1:0] X_LAST   = addr_w'(IMG_W - 3);
  localparam logic [addr_w-1:0] Y_LAST   = addr_w'(IMG_H - 3);
  localparam logic [addr_w-1:0] ROW_STEP = addr_w'(IMG_W);
  localparam logic [addr_w-1:0] DST_STEP = addr_w'(IMG_W - 2);
  localparam logic [addr_w-1:0] SRC_A    = addr_w'(SRC_BASE);
  localparam logic [addr_w-1:0] DST_A    = addr_w'(DST_BASE);

  state_t              state, nstate;
  logic [addr_w-1:0]   x, y, x_nxt, y_nxt, nxt_addr, dst_addr;
  logic                x_wrap, last_px;
  logic [3*data_w-1:0] row0, row1, row2;
  logic [data_w-1:0]   blur_q;

  blur3x3_div9 #(.data_w(data_w)) u_div9 (
    .row0 (row0),
    .row1 (row1),
    .row2 (row2),
    .q    (blur_q)
  );

  // Window position bookkeeping: next raster position and derived addresses.
  always_comb begin
    x_wrap  = (x == X_LAST);
    last_px = x_wrap && (y == Y_LAST);
    if (x_wrap) begin
      x_nxt = '0;
      y_nxt = y + addr_w'(1);
    end else begin
      x_nxt = x + addr_w'(1);
      y_nxt = y;
    end
    nxt_addr = SRC_A + y_nxt * ROW_STEP + x_nxt;
    dst_addr = DST_A + y * DST_STEP + x;
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  // FSM next-state logic.
  always_comb begin
    nstate = state;
    case (state)
      IDLE: begin
        if (START) begin
          nstate = RD0;
        end else begin
          nstate = IDLE;
        end
      end
      RD0:  nstate = RD1;
      RD1:  nstate = RD2;
      RD2:  nstate = CAP;
      CAP:  nstate = SUM;
      SUM:  nstate = OUT;
      OUT: begin
        if (OREADY && last_px) begin
          nstate = FIN;
        end else if (OREADY) begin
          nstate = NEXT;
        end else begin
          nstate = OUT;
        end
      end
      NEXT: nstate = RD0;
      FIN:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Registered datapath: read strobes/addresses one cycle ahead of their state,
  // triplet capture, result register and handshake/status outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ADDR   <= '0;
      RD     <= 1'b0;
      OADDR  <= '0;
      ODATA  <= '0;
      OVALID <= 1'b0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      x      <= '0;
      y      <= '0;
      row0   <= '0;
      row1   <= '0;
      row2   <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            ADDR <= SRC_A;
            RD   <= 1'b1;
            BUSY <= 1'b1;
            x    <= '0;
            y    <= '0;
          end
        end
        RD0: begin
          ADDR <= ADDR + ROW_STEP;
          RD   <= 1'b1;
        end
        RD1: begin
          ADDR <= ADDR + ROW_STEP;
          RD   <= 1'b1;
          row0 <= MDATA;
        end
        RD2: begin
          RD   <= 1'b0;
          row1 <= MDATA;
        end
        CAP: begin
          row2 <= MDATA;
        end
        SUM: begin
          ODATA  <= blur_q;
          OADDR  <= dst_addr;
          OVALID <= 1'b1;
        end
        OUT: begin
          if (OREADY) begin
            OVALID <= 1'b0;
            if (last_px) begin
              DONE <= 1'b1;
              BUSY <= 1'b0;
            end
          end
        end
        NEXT: begin
          x    <= x_nxt;
          y    <= y_nxt;
          ADDR <= nxt_addr;
          RD   <= 1'b1;
        end
        FIN: begin
          x <= '0;
          y <= '0;
        end
        default: begin
          RD <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blur3x3_engine.sv
// Self-checking bench for blur3x3_engine on a 4x4 frame with a behavioural
// 3-wide memory. Expected pixels are queued by the stimulus and checked by an
// independent monitor whenever OVALID&&OREADY.
module tb_blur3x3_engine;

  logic        CLK;
  logic        RST;
  logic        START;
  logic [7:0]  ADDR;
  logic        RD;
  logic [23:0] MDATA;
  logic [7:0]  OADDR;
  logic [7:0]  ODATA;
  logic        OVALID;
  logic        OREADY;
  logic        BUSY;
  logic        DONE;

  logic [7:0]  img [0:255];
  logic [15:0] sb [$];
  logic [15:0] mon_exp;
  int          checks;
  int          errors;
  int          done_cnt;

  blur3x3_engine #(
    .addr_w(8), .data_w(8), .IMG_W(4), .IMG_H(4), .SRC_BASE(0), .DST_BASE(0)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .ADDR(ADDR), .RD(RD), .MDATA(MDATA),
    .OADDR(OADDR), .ODATA(ODATA), .OVALID(OVALID), .OREADY(OREADY),
    .BUSY(BUSY), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // mem3wide model: one-cycle read latency, leftmost pixel in the low byte.
  always @(posedge CLK) begin
    if (RD) MDATA <= {img[ADDR + 8'd2], img[ADDR + 8'd1], img[ADDR]};
  end

  // Monitor: pop and compare on every accepted output, count DONE pulses.
  always @(negedge CLK) begin
    if (!RST) begin
      if (DONE) done_cnt++;
      if (OVALID && OREADY) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got OADDR=%0d ODATA=%0d, expected no output", OADDR, ODATA);
        end else begin
          mon_exp = sb.pop_front();
          if ({OADDR, ODATA} !== mon_exp) begin
            errors++;
            $display("FAIL pixel: got OADDR=%0d ODATA=%0d, expected OADDR=%0d ODATA=%0d",
                     OADDR, ODATA, mon_exp[15:8], mon_exp[7:0]);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int i = 0; i < 256; i++) img[i] = v;
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 256; i++) img[i] = (i < 16) ? 8'(i) : 8'd0;
  endtask

  task automatic push4(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    sb.push_back({8'd0, a});
    sb.push_back({8'd1, b});
    sb.push_back({8'd2, c});
    sb.push_back({8'd3, d});
  endtask

  task automatic start_pulse();
    @(posedge CLK); #1 START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
  endtask

  task automatic wait_done(input string name, output int n);
    int   busy_low;
    logic got;
    n = 0; busy_low = 0; got = 1'b0;
    while (!got && n < 400) begin
      @(negedge CLK);
      n++;
      if (DONE) got = 1'b1;
      else if (!BUSY) busy_low++;
    end
    chk({name, "_done_seen"}, int'(got), 1);
    chk({name, "_busy_held"}, busy_low, 0);
    chk({name, "_busy_clear_at_done"}, int'(BUSY), 0);
    @(negedge CLK);
    chk({name, "_done_one_cycle"}, int'(DONE), 0);
    chk({name, "_all_outputs_seen"}, sb.size(), 0);
  endtask

  task automatic wait_ovalid(output int lat);
    lat = 0;
    while (!OVALID && lat < 40) begin
      @(negedge CLK);
      lat++;
    end
  endtask

  initial begin
    int n, lat, snap, exp3;
    checks = 0; errors = 0; done_cnt = 0;
    START = 1'b0; OREADY = 1'b1; RST = 1'b0; MDATA = 24'd0;
    fill_const(8'd0);
    #2 RST = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_addr", ADDR, 0);
    chk("rst_rd", RD, 0);
    chk("rst_oaddr", OADDR, 0);
    chk("rst_odata", ODATA, 0);
    chk("rst_ovalid", OVALID, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    @(posedge CLK); #1 RST = 1'b0;

    // 1: flat 9s, latency and 7-cycle pixel rate.
    fill_const(8'd9);
    push4(8'd9, 8'd9, 8'd9, 8'd9);
    start_pulse();
    wait_ovalid(lat);
    chk("t1_latency", lat, 6);
    chk("t1_busy_at_ovalid", int'(BUSY), 1);
    wait_done("t1", n);
    chk("t1_start_to_done", lat + n, 28);
    chk("t1_done_count", done_cnt, 1);

    // 2: ramp x+4y, output equals centre pixel.
    fill_ramp();
    push4(8'd5, 8'd6, 8'd9, 8'd10);
    start_pulse();
    wait_done("t2", n);

    // 3: window sum 17.
`ifdef BLUR_ROUND_EN
    exp3 = 2;
`else
    exp3 = 1;
`endif
    fill_const(8'd2);
    img[5] = 8'd1;
    push4(8'(exp3), 8'(exp3), 8'(exp3), 8'(exp3));
    start_pulse();
    wait_done("t3", n);

    // 4: extremes.
    fill_const(8'd255);
    push4(8'd255, 8'd255, 8'd255, 8'd255);
    start_pulse();
    wait_done("t4_max", n);
    fill_const(8'd0);
    push4(8'd0, 8'd0, 8'd0, 8'd0);
    start_pulse();
    wait_done("t4_zero", n);

    // 5: back-pressure on the first output; also START while BUSY is ignored.
    fill_ramp();
    push4(8'd5, 8'd6, 8'd9, 8'd10);
    OREADY = 1'b0;
    start_pulse();
    wait_ovalid(lat);
    chk("t5_latency", lat, 6);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("t5_hold_ovalid", int'(OVALID), 1);
      chk("t5_hold_odata", ODATA, 5);
      chk("t5_hold_oaddr", OADDR, 0);
      chk("t5_no_read", int'(RD), 0);
    end
    @(posedge CLK); #1 START = 1'b1; OREADY = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
    wait_done("t5", n);

    // 6: reset during RD1 of the second pixel, then a clean restart.
    fill_const(8'd9);
    sb.push_back({8'd0, 8'd9});
    snap = done_cnt;
    start_pulse();
    n = 0;
    while (!(OVALID && OREADY) && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("t6_first_accept", int'(OVALID && OREADY), 1);
    n = 0;
    while (!RD && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("t6_second_rd0", int'(RD), 1);
    chk("t6_second_addr", ADDR, 1);
    @(posedge CLK);
    #1 RST = 1'b1;
    #1;
    chk("t6_rst_addr", ADDR, 0);
    chk("t6_rst_rd", RD, 0);
    chk("t6_rst_oaddr", OADDR, 0);
    chk("t6_rst_odata", ODATA, 0);
    chk("t6_rst_ovalid", OVALID, 0);
    chk("t6_rst_busy", BUSY, 0);
    chk("t6_rst_done", DONE, 0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("t6_no_done_after_abort", done_cnt, snap);
    chk("t6_first_pixel_seen", sb.size(), 0);
    push4(8'd9, 8'd9, 8'd9, 8'd9);
    start_pulse();
    wait_done("t6_restart", n);
    chk("t6_done_count", done_cnt, snap + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
